// File: rtl/hs_bus_amba_axilite_seq.sv
// Single-outstanding AXI-Lite manager: one cmd in, one AXI transaction, one rsp out.
// Optional response timeout with late-response drain: define HS_BUS_AMBA_AXILITE_SEQ_TIMEOUT_EN.
//
// state     | meaning
// ----------+----------------------------------------------------
// S_IDLE    | waiting for a command (blocked while draining)
// S_WR_REQ  | AW and W presented independently until both accepted
// S_WR_RESP | waiting for B
// S_RD_REQ  | AR presented until accepted
// S_RD_RESP | waiting for R
// S_RSP     | response held until rsp_ready
module hs_bus_amba_axilite_seq #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic                  wvalid,
  input  logic                  wready,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [STRB_WIDTH-1:0] wstrb,
  input  logic                  bvalid,
  output logic                  bready,
  input  logic [1:0]            bresp,
  output logic                  arvalid,
  input  logic                  arready,
  output logic [ADDR_WIDTH-1:0] araddr,
  input  logic                  rvalid,
  output logic                  rready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp
);

  if (TIMEOUT_CYCLES < 2) begin : g_timeout_chk
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_RESP, S_RSP
  } state_e;

  state_e                state_q, state_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]            rsp_resp_q, rsp_resp_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  arvalid_q, arvalid_d;
  logic                  bready_q, bready_d;
  logic                  rready_q, rready_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic                  idle_ok;

`ifdef HS_BUS_AMBA_AXILITE_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             drain_q, drain_d;
`endif

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    bready_d    = bready_q;
    rready_d    = rready_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    idle_ok     = 1'b1;
`ifdef HS_BUS_AMBA_AXILITE_SEQ_TIMEOUT_EN
    cnt_d   = cnt_q;
    drain_d = drain_q;
    // A response that arrives after a timeout is swallowed here, whatever the state.
    if (drain_q && ((bvalid && bready_q) || (rvalid && rready_q))) begin
      drain_d  = 1'b0;
      bready_d = 1'b0;
      rready_d = 1'b0;
    end
    idle_ok = ~drain_d;
`endif
    unique case (state_q)
      S_IDLE: begin
        cmd_ready_d = idle_ok;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          addr_d      = cmd_addr;
          wdata_d     = cmd_wdata;
          wstrb_d     = cmd_wstrb;
          if (cmd_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = S_WR_REQ;
          end else begin
            arvalid_d = 1'b1;
            state_d   = S_RD_REQ;
          end
        end
      end
      S_WR_REQ: begin
        if (awvalid_q && awready) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (wvalid_q && wready) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (aw_done_d && w_done_d) begin
          bready_d = 1'b1;
          state_d  = S_WR_RESP;
`ifdef HS_BUS_AMBA_AXILITE_SEQ_TIMEOUT_EN
          cnt_d = CNT_LOAD;
`endif
        end
      end
      S_WR_RESP: begin
        if (bvalid && bready_q) begin
          bready_d    = 1'b0;
          rsp_resp_d  = bresp;
          rsp_rdata_d = '0;
          rsp_valid_d = 1'b1;
          state_d     = S_RSP;
        end
`ifdef HS_BUS_AMBA_AXILITE_SEQ_TIMEOUT_EN
        else if (cnt_q == '0) begin
          rsp_resp_d  = 2'b10;
          rsp_rdata_d = '0;
          rsp_valid_d = 1'b1;
          drain_d     = 1'b1;
          state_d     = S_RSP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
`endif
      end
      S_RD_REQ: begin
        if (arvalid_q && arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD_RESP;
`ifdef HS_BUS_AMBA_AXILITE_SEQ_TIMEOUT_EN
          cnt_d = CNT_LOAD;
`endif
        end
      end
      S_RD_RESP: begin
        if (rvalid && rready_q) begin
          rready_d    = 1'b0;
          rsp_rdata_d = rdata;
          rsp_resp_d  = rresp;
          rsp_valid_d = 1'b1;
          state_d     = S_RSP;
        end
`ifdef HS_BUS_AMBA_AXILITE_SEQ_TIMEOUT_EN
        else if (cnt_q == '0) begin
          rsp_resp_d  = 2'b10;
          rsp_rdata_d = '0;
          rsp_valid_d = 1'b1;
          drain_d     = 1'b1;
          state_d     = S_RSP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
`endif
      end
      S_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = idle_ok;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      bready_q    <= bready_d;
      rready_q    <= rready_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
    end
  end

`ifdef HS_BUS_AMBA_AXILITE_SEQ_TIMEOUT_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q   <= '0;
      drain_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
    end
  end
`endif

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;
  assign awvalid   = awvalid_q;
  assign awaddr    = addr_q;
  assign wvalid    = wvalid_q;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign bready    = bready_q;
  assign arvalid   = arvalid_q;
  assign araddr    = addr_q;
  assign rready    = rready_q;

endmodule

// File: doc/hs_bus_amba_axilite_seq.md
Name:
hs_bus_amba_axilite_seq

Overview:
- Single-outstanding AXI5-Lite manager sequencer.
- Turns a simple valid/ready register-command stream (e.g. from a debug bridge or CSR init engine) into AXI-Lite read/write transactions.
- Returns one response per command.
- Sits between command sources and an AXI-Lite subordinate; no pipelining, strictly one transaction in flight.

Parameters:
ADDR_WIDTH, 32, address width of cmd and AW/AR
DATA_WIDTH, 32, data width of cmd, W and R
STRB_WIDTH, DATA_WIDTH/8, write strobe width
TIMEOUT_CYCLES, 256, response wait limit (used only with optional feature); min 2

Ports:
aclk  in  1  clock; one clock domain, all logic on rising edge
aresetn  in  1  asynchronous active-low reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command accept
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_WIDTH  target address
cmd_wdata  in  DATA_WIDTH  write data
cmd_wstrb  in  STRB_WIDTH  write strobes
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
rsp_resp  out  2  AXI response code
awvalid  out  1  AW valid
awready  in  1  AW ready
awaddr  out  ADDR_WIDTH  write address
wvalid  out  1  W valid
wready  in  1  W ready
wdata  out  DATA_WIDTH  write data
wstrb  out  STRB_WIDTH  write strobes
bvalid  in  1  B valid
bready  out  1  B ready
bresp  in  2  write response
arvalid  out  1  AR valid
arready  in  1  AR ready
araddr  out  ADDR_WIDTH  read address
rvalid  in  1  R valid
rready  out  1  R ready
rdata  in  DATA_WIDTH  read data
rresp  in  2  read response

Behaviour:
- Reset (async assert, sync release): state IDLE; cmd_ready=1; all other outputs 0, including all valids/readies, rsp_*, address/data regs.
- Reset mid-operation aborts the transaction immediately; no response is produced.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP. All outputs are registered.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, capture addr/wdata/wstrb.
  - Write: go to WR_REQ with awvalid=wvalid=1 on the next cycle.
  - Read: go to RD_REQ with arvalid=1 on the next cycle.
- WR_REQ: AW and W are independent.
  - Flags aw_done/w_done are set on the respective handshake; that valid drops the cycle after its handshake.
  - Valids and payload are held stable until handshake.
  - When both are done (same cycle allowed), go to WR_RESP with bready=1.
- WR_RESP: on bvalid&&bready, bready=0, rsp_resp=bresp, rsp_rdata=0, rsp_valid=1, go to RSP.
- RD_REQ: on arvalid&&arready, arvalid=0, rready=1, go to RD_RESP.
- RD_RESP: on rvalid&&rready, rsp_rdata=rdata, rsp_resp=rresp, rsp_valid=1, go to RSP.
- RSP: hold rsp_* stable until rsp_ready. Then rsp_valid=0, cmd_ready=1, go to IDLE.
- Minimum latency, cmd accept to rsp_valid, with subordinate always ready and zero-latency response:
  - Write: 3 cycles (WR_REQ, WR_RESP, RSP entry).
  - Read: 3 cycles.
- Back-to-back commands: next cmd accepted the cycle after the rsp handshake. No command overlap.
- Unsolicited bvalid/rvalid outside their wait states are ignored (readies stay 0).

Optional Feature:
- Macro: HS_BUS_AMBA_AXILITE_SEQ_TIMEOUT_EN.
- Enabled:
  - A cycle counter runs only in WR_RESP/RD_RESP (address/data phases are never abandoned). It resets on entry to those states.
  - On reaching TIMEOUT_CYCLES: go to RSP with rsp_resp=2'b10 (SLVERR), rsp_rdata=0, and set internal drain flag.
  - While drain is set, bready/rready stay 1 in IDLE and cmd_ready=0. The late B/R is consumed and discarded, then drain clears and cmd_ready=1.
- Disabled: no counter; the block waits indefinitely for B/R.

Test Plan:
- Write 0x1000 data 0xA5A5_A5A5 strb 0xF; AW/W/B ready immediately, bresp=0 -> awaddr=0x1000, wdata=0xA5A5A5A5, rsp_valid 3 cycles after accept, rsp_resp=0, rsp_rdata=0.
- Read 0x2004; arready after 4 cycles, rdata=0x1234_5678 rresp=2'b00 -> arvalid held 4 cycles with stable araddr; rsp_rdata=0x12345678.
- Write with wready 3 cycles before awready -> wvalid drops after W handshake, awvalid held; exactly one B consumed; rsp_resp=bresp (inject 2'b10, check 2'b10).
- rsp_ready held 0 for 5 cycles -> rsp_* stable, cmd_ready=0, second cmd_valid not accepted until cycle after rsp handshake.
- aresetn pulsed low during RD_RESP -> all valids/readies 0 asynchronously, no rsp_valid, next read completes normally.
- Macro on, TIMEOUT_CYCLES=8, bvalid withheld 20 cycles -> rsp_resp=2'b10 after 8 waiting cycles; cmd_ready=0 until late B consumed with bready=1.
